// File: rtl/core_pkg.sv
// Shared core definitions used by the reorder buffer and its retire logic.
// Provides:
//   XLEN        - architectural data width
//   ROB_DEPTH   - number of reorder-buffer entries (power of two, >= 4)
//   ROB_TAG_W   - width of an entry index
//   rob_tag_t   - entry index type
//   rob_entry_t - per-entry bookkeeping (valid, done, exc, has_rd, rd, data)
package core_pkg;

  localparam int XLEN      = 64;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic            valid;
    logic            done;
    logic            exc;
    logic            has_rd;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_if.sv
// Bundle of dispatch, writeback and commit signals for the reorder buffer.
// Modports:
//   slave  - the reorder buffer (consumes dispatch/writeback, drives commit)
//   master - the surrounding core (drives dispatch/writeback, observes commit)
// Signals:
//   disp_valid/disp_has_rd/disp_rd -> dispatch request, two packed slots
//   disp_ready/disp_tag            <- dispatch acceptance and assigned tags
//   wb_valid/wb_tag/wb_data/wb_exc -> two execution writeback ports
//   commit_wen/waddr/wdata/count   <- registered ARF write ports
//   exc_valid/exc_tag              <- registered one-cycle flush pulse
//   rob_empty                      <- buffer holds no entries
interface rob_commit_if;
  import core_pkg::*;

  logic [1:0]                      disp_valid;
  logic [1:0]                      disp_has_rd;
  logic [1:0][4:0]                 disp_rd;
  logic                            disp_ready;
  logic [1:0][ROB_TAG_W-1:0]       disp_tag;

  logic [1:0]                      wb_valid;
  logic [1:0][ROB_TAG_W-1:0]       wb_tag;
  logic [1:0][XLEN-1:0]            wb_data;
  logic [1:0]                      wb_exc;

  logic [1:0]                      commit_wen;
  logic [1:0][4:0]                 commit_waddr;
  logic [1:0][XLEN-1:0]            commit_wdata;
  logic [1:0]                      commit_count;
  logic                            exc_valid;
  logic [ROB_TAG_W-1:0]            exc_tag;
  logic                            rob_empty;

  modport slave (
    input  disp_valid, disp_has_rd, disp_rd,
    output disp_ready, disp_tag,
    input  wb_valid, wb_tag, wb_data, wb_exc,
    output commit_wen, commit_waddr, commit_wdata, commit_count,
    output exc_valid, exc_tag, rob_empty
  );

  modport master (
    output disp_valid, disp_has_rd, disp_rd,
    input  disp_ready, disp_tag,
    output wb_valid, wb_tag, wb_data, wb_exc,
    input  commit_wen, commit_waddr, commit_wdata, commit_count,
    input  exc_valid, exc_tag, rob_empty
  );

endinterface

// File: rtl/rob_retire_sel.sv
// Combinational retire selection for the two oldest reorder-buffer entries.
// Ports:
//   head0_i, head1_i - entries at head and head+1
//   retire0_o        - head entry retires this cycle
//   retire1_o        - head+1 entry retires alongside it
//   flush_o          - head entry completed with an exception
//   wen_o            - ARF write enables after rd=0 / collision masking
//   waddr_o, wdata_o - ARF address/data per slot, zero when not retiring
module rob_retire_sel import core_pkg::*; (
  input  rob_entry_t            head0_i,
  input  rob_entry_t            head1_i,
  output logic                  retire0_o,
  output logic                  retire1_o,
  output logic                  flush_o,
  output logic [1:0]            wen_o,
  output logic [1:0][4:0]       waddr_o,
  output logic [1:0][XLEN-1:0]  wdata_o
);

  logic wen0Raw;
  logic wen1;

  // Slot 1 may only retire behind slot 0, so an exception at head+1 lets
  // the head retire alone and is handled once it becomes the head.
  // When both slots target the same register, the ARF would keep port 0,
  // so port 0 is suppressed to let the younger result land.
  always_comb begin
    flush_o   = head0_i.valid && head0_i.done && head0_i.exc;
    retire0_o = head0_i.valid && head0_i.done && !head0_i.exc;
    retire1_o = retire0_o && head1_i.valid && head1_i.done && !head1_i.exc;

    wen0Raw   = retire0_o && head0_i.has_rd && (head0_i.rd != 5'd0);
    wen1      = retire1_o && head1_i.has_rd && (head1_i.rd != 5'd0);

    wen_o[0]  = wen0Raw && !(wen1 && (head0_i.rd == head1_i.rd));
    wen_o[1]  = wen1;

    waddr_o[0] = retire0_o ? head0_i.rd   : 5'd0;
    waddr_o[1] = retire1_o ? head1_i.rd   : 5'd0;
    wdata_o[0] = retire0_o ? head0_i.data : '0;
    wdata_o[1] = retire1_o ? head1_i.data : '0;
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with two-wide dispatch, two writeback ports and a
// two-wide in-order retire stage driving the architectural register file.
// An excepting instruction reaching the head flushes the whole buffer.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   bus   - rob_commit_if.slave (dispatch, writeback, commit, flush, empty)
module rob_commit #(
  parameter int XLEN      = core_pkg::XLEN,
  parameter int ROB_DEPTH = core_pkg::ROB_DEPTH,
  parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  rob_commit_if.slave bus
);
  import core_pkg::*;

  localparam int CNT_W = TAG_W + 1;

  rob_entry_t             entry_q [ROB_DEPTH];
  rob_entry_t             entry_d [ROB_DEPTH];
  logic [TAG_W-1:0]       head_q, head_d;
  logic [TAG_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [1:0]             commitWen_q;
  logic [1:0][4:0]        commitWaddr_q;
  logic [1:0][XLEN-1:0]   commitWdata_q;
  logic [1:0]             commitCount_q;
  logic                   excValid_q;
  logic [TAG_W-1:0]       excTag_q;

  logic [TAG_W-1:0]       headNext;
  logic [TAG_W-1:0]       tailNext;
  logic                   retire0, retire1, flush;
  logic [1:0]             selWen;
  logic [1:0][4:0]        selWaddr;
  logic [1:0][XLEN-1:0]   selWdata;
  logic                   dispReady;
  logic                   accept0, accept1;
  logic [1:0]             numAccept, numRetire;
  rob_entry_t             newEntry0, newEntry1;

  assign headNext = head_q + 1'b1;
  assign tailNext = tail_q + 1'b1;

  rob_retire_sel u_retire_sel (
    .head0_i   (entry_q[head_q]),
    .head1_i   (entry_q[headNext]),
    .retire0_o (retire0),
    .retire1_o (retire1),
    .flush_o   (flush),
    .wen_o     (selWen),
    .waddr_o   (selWaddr),
    .wdata_o   (selWdata)
  );

  // Dispatch needs room for a full pair; a lone slot-1 request is not a
  // legal packing and is dropped entirely.
  always_comb begin
    dispReady = (count_q <= CNT_W'(ROB_DEPTH - 2)) && !flush && !reset;
    accept0   = dispReady && bus.disp_valid[0];
    accept1   = dispReady && (bus.disp_valid == 2'b11);
    numAccept = {1'b0, accept0} + {1'b0, accept1};
    numRetire = {1'b0, retire0} + {1'b0, retire1};

    newEntry0        = '0;
    newEntry0.valid  = 1'b1;
    newEntry0.has_rd = bus.disp_has_rd[0];
    newEntry0.rd     = bus.disp_rd[0];
    newEntry1        = '0;
    newEntry1.valid  = 1'b1;
    newEntry1.has_rd = bus.disp_has_rd[1];
    newEntry1.rd     = bus.disp_rd[1];
  end

  // Next-state for the entry array and pointers. Writebacks only land on
  // entries that were already valid, with port 1 applied last so it wins a
  // same-tag race; retirement invalidation follows so a late writeback
  // cannot resurrect a retired entry.
  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entry_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (bus.wb_valid[p] && entry_q[bus.wb_tag[p]].valid) begin
          entry_d[bus.wb_tag[p]].done = 1'b1;
          entry_d[bus.wb_tag[p]].exc  = bus.wb_exc[p];
          entry_d[bus.wb_tag[p]].data = bus.wb_data[p];
        end
      end
      if (retire0) begin
        entry_d[head_q].valid = 1'b0;
      end
      if (retire1) begin
        entry_d[headNext].valid = 1'b0;
      end
      if (accept0) begin
        entry_d[tail_q] = newEntry0;
      end
      if (accept1) begin
        entry_d[tailNext] = newEntry1;
      end
      head_d  = head_q + TAG_W'(numRetire);
      tail_d  = tail_q + TAG_W'(numAccept);
      count_d = count_q + CNT_W'(numAccept) - CNT_W'(numRetire);
    end
  end

  // State and registered commit outputs. A flush reports the head tag for
  // one cycle; the selector already holds write enables low in that case.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commitWen_q   <= '0;
      commitWaddr_q <= '0;
      commitWdata_q <= '0;
      commitCount_q <= '0;
      excValid_q    <= 1'b0;
      excTag_q      <= '0;
    end else begin
      entry_q       <= entry_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commitWen_q   <= selWen;
      commitWaddr_q <= selWaddr;
      commitWdata_q <= selWdata;
      commitCount_q <= numRetire;
      excValid_q    <= flush;
      excTag_q      <= flush ? head_q : '0;
    end
  end

  assign bus.disp_ready   = dispReady;
  assign bus.disp_tag[0]  = tail_q;
  assign bus.disp_tag[1]  = tailNext;
  assign bus.commit_wen   = commitWen_q;
  assign bus.commit_waddr = commitWaddr_q;
  assign bus.commit_wdata = commitWdata_q;
  assign bus.commit_count = commitCount_q;
  assign bus.exc_valid    = excValid_q;
  assign bus.exc_tag      = excTag_q;
  assign bus.rob_empty    = (count_q == '0);

endmodule

// File: tb/tb_rob_commit.sv
// Testbench for rob_commit: directed scenarios followed by random traffic,
// checked against a queue-based program-order model and a scoreboard.
module tb_rob_commit;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  rob_commit_if bus ();

  rob_commit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          tag;
    bit          done;
    bit          exc;
    bit          hasRd;
    int          rd;
    logic [63:0] data;
  } mEntry_t;

  typedef struct {
    bit          isExc;
    int          tag;
    int          cnt;
    logic [1:0]  wen;
    logic [4:0]  waddr0;
    logic [4:0]  waddr1;
    logic [63:0] wdata0;
    logic [63:0] wdata1;
  } expect_t;

  mEntry_t mq[$];
  int      mTail = 0;
  expect_t sb[$];
  int      total = 0;
  int      bad = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, compare combinational outputs
  // against the model, then advance the model with the sampled edge.
  task automatic applyStimulus(input bit rst, input logic [1:0] dv, input logic [1:0] hr,
                               input logic [4:0] rd0, input logic [4:0] rd1,
                               input logic [1:0] wv, input int wt0, input int wt1,
                               input logic [63:0] wd0, input logic [63:0] wd1,
                               input logic [1:0] wx);
    bit          flushNow;
    bit          rdy;
    int          n;
    expect_t     e;
    mEntry_t     m;
    int          wt[2];
    logic [63:0] wd[2];

    @(negedge clk);
    reset               = rst;
    bus.disp_valid      = dv;
    bus.disp_has_rd     = hr;
    bus.disp_rd[0]      = rd0;
    bus.disp_rd[1]      = rd1;
    bus.wb_valid        = wv;
    bus.wb_tag[0]       = ROB_TAG_W'(wt0);
    bus.wb_tag[1]       = ROB_TAG_W'(wt1);
    bus.wb_data[0]      = wd0;
    bus.wb_data[1]      = wd1;
    bus.wb_exc          = wx;
    #1;
    flushNow = (mq.size() > 0) && mq[0].done && mq[0].exc;
    rdy      = (ROB_DEPTH - mq.size() >= 2) && !flushNow && !rst;
    checkOutput("disp_ready", 64'(bus.disp_ready), 64'(rdy));
    checkOutput("disp_tag0", 64'(bus.disp_tag[0]), 64'(mTail % ROB_DEPTH));
    checkOutput("disp_tag1", 64'(bus.disp_tag[1]), 64'((mTail + 1) % ROB_DEPTH));
    checkOutput("rob_empty", 64'(bus.rob_empty), 64'(mq.size() == 0));

    @(posedge clk);
    wt[0] = wt0; wt[1] = wt1; wd[0] = wd0; wd[1] = wd1;
    if (rst) begin
      mq.delete();
      mTail = 0;
    end else if (flushNow) begin
      e = '{isExc: 1'b1, tag: mq[0].tag, cnt: 0, wen: 2'b00,
            waddr0: 5'd0, waddr1: 5'd0, wdata0: 64'd0, wdata1: 64'd0};
      sb.push_back(e);
      mq.delete();
      mTail = 0;
    end else begin
      n = 0;
      if (mq.size() > 0 && mq[0].done && !mq[0].exc) n = 1;
      if (n == 1 && mq.size() > 1 && mq[1].done && !mq[1].exc) n = 2;
      if (n > 0) begin
        e = '{isExc: 1'b0, tag: 0, cnt: n, wen: 2'b00,
              waddr0: 5'(mq[0].rd), waddr1: 5'd0, wdata0: mq[0].data, wdata1: 64'd0};
        e.wen[0] = mq[0].hasRd && (mq[0].rd != 0);
        if (n == 2) begin
          e.wen[1] = mq[1].hasRd && (mq[1].rd != 0);
          e.waddr1 = 5'(mq[1].rd);
          e.wdata1 = mq[1].data;
          if (e.wen[0] && e.wen[1] && mq[0].rd == mq[1].rd) e.wen[0] = 1'b0;
        end
        sb.push_back(e);
        for (int k = 0; k < n; k++) void'(mq.pop_front());
      end
      for (int p = 0; p < 2; p++) begin
        if (wv[p]) begin
          for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].tag == wt[p]) begin
              m = mq[k];
              m.done = 1'b1;
              m.exc  = wx[p];
              m.data = wd[p];
              mq[k]  = m;
            end
          end
        end
      end
      if (rdy && dv[0]) begin
        mq.push_back('{tag: mTail, done: 1'b0, exc: 1'b0, hasRd: hr[0], rd: int'(rd0), data: 64'd0});
        mTail = (mTail + 1) % ROB_DEPTH;
      end
      if (rdy && dv == 2'b11) begin
        mq.push_back('{tag: mTail, done: 1'b0, exc: 1'b0, hasRd: hr[1], rd: int'(rd1), data: 64'd0});
        mTail = (mTail + 1) % ROB_DEPTH;
      end
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);
  endtask

  // Scoreboard monitor: every registered commit/flush event must match the
  // next expectation; cycles with nothing expected must show idle outputs.
  initial begin
    expect_t ex;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        ex = sb.pop_front();
      end else begin
        ex = '{isExc: 1'b0, tag: 0, cnt: 0, wen: 2'b00,
               waddr0: 5'd0, waddr1: 5'd0, wdata0: 64'd0, wdata1: 64'd0};
      end
      checkOutput("exc_valid", 64'(bus.exc_valid), 64'(ex.isExc));
      checkOutput("commit_count", 64'(bus.commit_count), 64'(ex.cnt));
      checkOutput("commit_wen", 64'(bus.commit_wen), 64'(ex.wen));
      if (ex.isExc) checkOutput("exc_tag", 64'(bus.exc_tag), 64'(ex.tag));
      if (ex.wen[0]) begin
        checkOutput("waddr0", 64'(bus.commit_waddr[0]), 64'(ex.waddr0));
        checkOutput("wdata0", bus.commit_wdata[0], ex.wdata0);
      end
      if (ex.wen[1]) begin
        checkOutput("waddr1", 64'(bus.commit_waddr[1]), 64'(ex.waddr1));
        checkOutput("wdata1", bus.commit_wdata[1], ex.wdata1);
      end
    end
  end

  initial begin
    logic [1:0]  dv;
    logic [1:0]  wv;
    logic [1:0]  wx;
    int          t0;
    int          t1;

    bus.disp_valid = '0; bus.disp_has_rd = '0; bus.disp_rd = '0;
    bus.wb_valid = '0; bus.wb_tag = '0; bus.wb_data = '0; bus.wb_exc = '0;

    applyStimulus(1'b1, 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);
    applyStimulus(1'b1, 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);
    #1;
    checkOutput("rst_count", 64'(bus.commit_count), 64'd0);
    checkOutput("rst_empty", 64'(bus.rob_empty), 64'd1);

    // Pair with distinct destinations, both written back together.
    applyStimulus(1'b0, 2'b11, 2'b11, 5'd3, 5'd5, 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b11, 0, 1, 64'h11, 64'h22, 2'b00);
    idleCycle();
    #1;
    checkOutput("t1_wen", 64'(bus.commit_wen), 64'd3);
    checkOutput("t1_count", 64'(bus.commit_count), 64'd2);
    checkOutput("t1_waddr1", 64'(bus.commit_waddr[1]), 64'd5);
    checkOutput("t1_wdata0", bus.commit_wdata[0], 64'h11);
    idleCycle();
    #1;
    checkOutput("t1_empty", 64'(bus.rob_empty), 64'd1);

    // Same destination in both slots: only the younger write survives.
    applyStimulus(1'b0, 2'b11, 2'b11, 5'd7, 5'd7, 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b11, 2, 3, 64'hA, 64'hB, 2'b00);
    idleCycle();
    #1;
    checkOutput("t2_wen", 64'(bus.commit_wen), 64'd2);
    checkOutput("t2_waddr1", 64'(bus.commit_waddr[1]), 64'd7);
    checkOutput("t2_wdata1", bus.commit_wdata[1], 64'hB);

    // Out-of-order completion waits for the oldest entry.
    applyStimulus(1'b0, 2'b11, 2'b11, 5'd1, 5'd2, 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b11, 5'd3, 5'd4, 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b11, 5, 6, 64'h55, 64'h66, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b01, 7, 0, 64'h77, 64'd0, 2'b00);
    idleCycle();
    #1;
    checkOutput("t3_hold", 64'(bus.commit_count), 64'd0);
    applyStimulus(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b01, 4, 0, 64'h44, 64'd0, 2'b00);
    idleCycle();
    #1;
    checkOutput("t3_first", 64'(bus.commit_count), 64'd2);
    idleCycle();
    #1;
    checkOutput("t3_second", 64'(bus.commit_count), 64'd2);

    // Exception behind a completed head: head retires, then flush.
    applyStimulus(1'b0, 2'b11, 2'b11, 5'd8, 5'd9, 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b01, 5'd10, 5'd0, 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b11, 8, 9, 64'h88, 64'h99, 2'b10);
    idleCycle();
    #1;
    checkOutput("t4_single", 64'(bus.commit_count), 64'd1);
    idleCycle();
    #1;
    checkOutput("t4_exc", 64'(bus.exc_valid), 64'd1);
    checkOutput("t4_exc_tag", 64'(bus.exc_tag), 64'd9);
    checkOutput("t4_empty", 64'(bus.rob_empty), 64'd1);

    // Fill to 15 entries, free one, then dispatch across the wrap.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 2'b11, 2'b11, 5'(i + 1), 5'(i + 8), 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);
    end
    applyStimulus(1'b0, 2'b01, 2'b01, 5'd20, 5'd0, 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);
    #1;
    checkOutput("full_ready", 64'(bus.disp_ready), 64'd0);
    applyStimulus(1'b0, 2'b11, 2'b11, 5'd21, 5'd22, 2'b01, 0, 0, 64'hF0, 64'd0, 2'b00);
    idleCycle();
    #1;
    checkOutput("wrap_ready", 64'(bus.disp_ready), 64'd1);
    checkOutput("wrap_tag0", 64'(bus.disp_tag[0]), 64'd15);
    checkOutput("wrap_tag1", 64'(bus.disp_tag[1]), 64'd0);
    applyStimulus(1'b0, 2'b11, 2'b11, 5'd23, 5'd24, 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);

    // Reset while the buffer is full and dispatch is requested.
    applyStimulus(1'b1, 2'b11, 2'b11, 5'd1, 5'd2, 2'b11, 1, 2, 64'h1, 64'h2, 2'b00);
    #1;
    checkOutput("mid_rst_count", 64'(bus.commit_count), 64'd0);
    checkOutput("mid_rst_empty", 64'(bus.rob_empty), 64'd1);

    // Retiring entries without a usable destination still count.
    applyStimulus(1'b0, 2'b11, 2'b10, 5'd9, 5'd0, 2'b00, 0, 0, 64'd0, 64'd0, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 2'b11, 0, 1, 64'h5, 64'h6, 2'b00);
    idleCycle();
    #1;
    checkOutput("nord_count", 64'(bus.commit_count), 64'd2);
    checkOutput("nord_wen", 64'(bus.commit_wen), 64'd0);

    // Random traffic, including illegal 2'b10 dispatch and sporadic resets.
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 4))
        0:       dv = 2'b00;
        1:       dv = 2'b01;
        2:       dv = 2'b10;
        default: dv = 2'b11;
      endcase
      wv = 2'($urandom_range(0, 3));
      wx[0] = ($urandom_range(0, 23) == 0);
      wx[1] = ($urandom_range(0, 23) == 0);
      if (mq.size() > 0) begin
        t0 = mq[$urandom_range(0, mq.size() - 1)].tag;
        t1 = mq[$urandom_range(0, mq.size() - 1)].tag;
      end else begin
        t0 = $urandom_range(0, ROB_DEPTH - 1);
        t1 = $urandom_range(0, ROB_DEPTH - 1);
      end
      applyStimulus($urandom_range(0, 299) == 0, dv, 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    wv, t0, t1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, wx);
    end

    idleCycle();
    idleCycle();
    @(negedge clk);
    #1;
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
